// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter: read latency and
// the tag carried alongside an in-flight read.
package ram_arb_pkg;

  localparam int RD_LATENCY = 2;
  localparam int MAX_REQ    = 8;

  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W = tag_width(MAX_REQ);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter: double-width masked priority encode
// starting at the pointer, pointer advances past the winner on each grant.
module rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int PRIO_FIXED = 0,
  localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      win_o
);

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0]   dbl;
  logic                   found;

  always_comb begin
    dbl   = {req_i, req_i};
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    // Upper copy of the request vector lets the search wrap past NUM_REQ-1.
    for (int k = 0; k < 2*NUM_REQ; k++) begin
      if (!found && dbl[k] && (PRIO_FIXED != 0 || k >= int'(ptr_q))) begin
        found = 1'b1;
        win_o = PW'(k % NUM_REQ);
      end
    end
    if (found) gnt_o[win_o] = 1'b1;
    ptr_d = ptr_q;
    if (found && PRIO_FIXED == 0)
      ptr_d = (win_o == PW'(NUM_REQ-1)) ? '0 : win_o + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters: registered command stage,
// two-stage read tag pipeline steering read data back to the issuer.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int PRIO_FIXED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [ADDR_W-1:0]         ram_addra,
  output logic [DATA_W-1:0]         ram_dina,
  input  logic [DATA_W-1:0]         ram_douta
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      win;
  logic               accept, rd_acc;

  logic               ena_q, ena_d, wea_q, wea_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  rd_tag_t            tag1_q, tag1_d, tag2_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PRIO_FIXED(PRIO_FIXED)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .gnt_o (gnt),
    .win_o (win)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign rd_acc    = accept && !req_we[win];

  always_comb begin
    ena_d      = accept;
    wea_d      = accept && req_we[win];
    addr_d     = addr_q;
    din_d      = din_q;
    tag1_d.vld = rd_acc;
    tag1_d.id  = TAG_W'(win);
    if (accept) begin
      addr_d = req_addr[win*ADDR_W +: ADDR_W];
      din_d  = req_wdata[win*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q  <= 1'b0;
      wea_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      ena_q  <= ena_d;
      wea_q  <= wea_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      tag1_q <= tag1_d;
      tag2_q <= tag1_q;
    end
  end

  assign ram_ena   = ena_q;
  assign ram_wea   = wea_q;
  assign ram_addra = addr_q;
  assign ram_dina  = din_q;

  // Stage-2 tag lines up with douta of the read it describes.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = tag2_q.vld && (tag2_q.id == TAG_W'(i));
  end

  assign rsp_data = tag2_q.vld ? ram_douta : '0;

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
  assert property (@(posedge clk) disable iff (!rst_n) (|rsp_valid) |-> $past(rd_acc, RD_LATENCY));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: round-robin DUT and fixed-priority DUT driven in parallel,
// each with its own behavioural single-port RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_we;
  logic [7:0] a0, a1, d0, d1;
  logic [15:0] req_addr, req_wdata;

  logic [1:0] req_ready, rsp_valid, req_ready_f, rsp_valid_f;
  logic [7:0] rsp_data, rsp_data_f;
  logic       ram_ena, ram_wea, ram_ena_f, ram_wea_f;
  logic [7:0] ram_addra, ram_dina, ram_douta, ram_addra_f, ram_dina_f, ram_douta_f;

  logic [7:0] mem   [256];
  logic [7:0] mem_f [256];

  int n_checks = 0;
  int n_fail   = 0;

  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .PRIO_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_ena(ram_ena),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_douta(ram_douta));

  ram_port_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .PRIO_FIXED(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_f),
    .rsp_valid(rsp_valid_f), .rsp_data(rsp_data_f), .ram_ena(ram_ena_f),
    .ram_wea(ram_wea_f), .ram_addra(ram_addra_f), .ram_dina(ram_dina_f),
    .ram_douta(ram_douta_f));

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      ram_douta <= mem[ram_addra];
    end
    if (ram_ena_f) begin
      if (ram_wea_f) mem_f[ram_addra_f] <= ram_dina_f;
      ram_douta_f <= mem_f[ram_addra_f];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_we = 2'b00;
    a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, ram_ena, ram_wea, ram_addra, ram_dina} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b rsp=%b data=%h ena=%b wea=%b addr=%h din=%h, want all 0",
               req_ready, rsp_valid, rsp_data, ram_ena, ram_wea, ram_addra, ram_dina);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; req_we = 2'b00; a0 = 8'd5;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({ram_ena, ram_wea, ram_addra, rsp_valid} !== {1'b1, 1'b0, 8'd5, 2'b00}) begin
      n_fail++;
      $display("FAIL single_cmd: got ena=%b wea=%b addr=%h rsp=%b want 1 0 05 00", ram_ena, ram_wea, ram_addra, rsp_valid);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_rsp: got rsp=%b data=%h want 01 a5", rsp_valid, rsp_data);
    end
    cyc();
  endtask

  task automatic test_write_read();
    req_valid = 2'b01; req_we = 2'b01; a0 = 8'd3; d0 = 8'h3C;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    cyc();
    req_valid = 2'b10; req_we = 2'b00; a1 = 8'd3; a0 = 8'd0; d0 = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({req_ready, ram_ena, ram_wea, ram_addra, ram_dina} !== {2'b10, 1'b1, 1'b1, 8'd3, 8'h3C}) begin
      n_fail++;
      $display("FAIL wr_cmd: got ready=%b ena=%b wea=%b addr=%h din=%h want 10 1 1 03 3c",
               req_ready, ram_ena, ram_wea, ram_addra, ram_dina);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({ram_ena, ram_wea, rsp_valid} !== {1'b1, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL rd_after_wr_cmd: got ena=%b wea=%b rsp=%b want 1 0 00", ram_ena, ram_wea, rsp_valid);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL rd_after_wr_rsp: got rsp=%b data=%h want 10 3c", rsp_valid, rsp_data);
    end
    cyc();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g, exp_r;
    logic [7:0] exp_d;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin req_valid = 2'b11; req_we = 2'b00; a0 = 8'd0; a1 = 8'd1; end
      else idle_inputs();
      @(negedge clk);
      if (c < 4) begin
        exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++;
        if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
        n_checks++;
        if (req_ready_f !== 2'b01) begin n_fail++; $display("FAIL fixed_grant c=%0d: got %b want 01", c, req_ready_f); end
      end
      if (c >= 2) begin
        exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = (c % 2 == 0) ? 8'h10 : 8'h11;
        n_checks++;
        if (rsp_valid !== exp_r || rsp_data !== exp_d) begin
          n_fail++;
          $display("FAIL rr_rsp c=%0d: got rsp=%b data=%h want %b %h", c, rsp_valid, rsp_data, exp_r, exp_d);
        end
        n_checks++;
        if (rsp_valid_f !== 2'b01 || rsp_data_f !== 8'h10) begin
          n_fail++;
          $display("FAIL fixed_rsp c=%0d: got rsp=%b data=%h want 01 10", c, rsp_valid_f, rsp_data_f);
        end
      end
      cyc();
    end
  endtask

  task automatic test_idle_gap();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ram_ena, ram_wea, rsp_valid, ram_addra} !== {1'b0, 1'b0, 2'b00, 8'd1}) begin
        n_fail++;
        $display("FAIL idle c=%0d: got ena=%b wea=%b rsp=%b addr=%h want 0 0 00 01", c, ram_ena, ram_wea, rsp_valid, ram_addra);
      end
      cyc();
    end
    req_valid = 2'b11; a0 = 8'd0; a1 = 8'd1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL idle_ptr_hold: got %b want 01", req_ready); end
    cyc();
    idle_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_reset_midop();
    req_valid = 2'b10; a1 = 8'd1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL midop_grant_a: got %b want 10", req_ready); end
    cyc();
    req_valid = 2'b01; a0 = 8'd5; a1 = 8'd0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midop_grant_b: got %b want 01", req_ready); end
    cyc();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, ram_ena, ram_wea, ram_addra, ram_dina} !== 30'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got ready=%b rsp=%b data=%h ena=%b wea=%b addr=%h din=%h, want all 0",
               req_ready, rsp_valid, rsp_data, ram_ena, ram_wea, ram_addra, ram_dina);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midop_no_rsp c=%0d: got %b want 00", c, rsp_valid); end
      cyc();
    end
    req_valid = 2'b01; a0 = 8'd5;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_grant: got %b want 01", req_ready); end
    cyc();
    idle_inputs();
    cyc();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL post_reset_rsp: got rsp=%b data=%h want 01 a5", rsp_valid, rsp_data);
    end
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i ^ 8'h5A);
      mem_f[i] = 8'(i ^ 8'h5A);
    end
    mem[5] = 8'hA5; mem[0] = 8'h10; mem[1] = 8'h11;
    mem_f[5] = 8'hA5; mem_f[0] = 8'h10; mem_f[1] = 8'h11;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_idle_gap();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
